// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 receiver and the keyboard command decoder.
//   - ps2_state_e    : receiver frame FSM states
//   - PS2_BREAK/EXT  : break and extended prefix bytes
//   - KEY_*          : make codes the downstream decoder acts on
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] KEY_C     = 8'h21;
  localparam logic [7:0] KEY_G     = 8'h34;
  localparam logic [7:0] KEY_H     = 8'h33;
  localparam logic [7:0] KEY_T     = 8'h2C;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_R     = 8'h2D;
  localparam logic [7:0] KEY_S     = 8'h1B;

endpackage

// File: rtl/ps2_filtro.sv
// ps2_filtro: input conditioning for the raw PS/2 pins.
//   clk_i      system clock
//   rst_ni     async active-low reset
//   ps2_clk_i  raw PS/2 clock pin (asynchronous)
//   ps2_data_i raw PS/2 data pin (asynchronous)
//   bit_evt_o  one-cycle pulse on a filtered 1->0 edge of ps2_clk
//   data_s_o   synchronised ps2_data, valid to sample with bit_evt_o
// The filtered clock changes level only after FILTER_LEN identical
// synchronised samples; shorter glitches are held off.
module ps2_filtro #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic bit_evt_o,
  output logic data_s_o
);

  logic [1:0]            clk_sync_q;
  logic [1:0]            dat_sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  filt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      hist_q     <= '1;
      filt_q     <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      hist_q     <= {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
      if (&hist_q)       filt_q <= 1'b1;
      else if (~|hist_q) filt_q <= 1'b0;
    end
  end

  // Event fires in the cycle the filtered level is about to drop.
  assign bit_evt_o = filt_q & ~|hist_q;
  assign data_s_o  = dat_sync_q[1];

endmodule

// File: rtl/ps2_receptor.sv
// ps2_receptor: PS/2 keyboard frame receiver feeding the command decoder.
//   CLK_chaos   system clock
//   restart_n   async active-low reset
//   ps2_clk     raw PS/2 clock pin
//   ps2_data    raw PS/2 data pin
//   dato        last accepted make code (held)
//   dato_listo  one-cycle pulse whenever dato is written
//   error_trama one-cycle pulse on parity, stop or timeout error
//   ocupado     high while a frame is in progress
// Build option: PS2_BREAK_CLEAR_EN - a break for the code currently on dato
// clears dato to 8'h00 and pulses dato_listo (key-release visibility).
module ps2_receptor
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       CLK_chaos,
  input  logic       restart_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] dato,
  output logic       dato_listo,
  output logic       error_trama,
  output logic       ocupado
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic bit_evt, data_s;

  ps2_filtro #(.FILTER_LEN(FILTER_LEN)) u_filtro (
    .clk_i      (CLK_chaos),
    .rst_ni     (restart_n),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .bit_evt_o  (bit_evt),
    .data_s_o   (data_s)
  );

  ps2_state_e      state_q;
  logic [2:0]      cnt_q;
  logic [7:0]      shreg_q;
  logic            par_q;
  logic [TO_W-1:0] to_q;
  logic            brk_q, ext_q;
  logic [7:0]      dato_q;
  logic            listo_q, err_q, ocup_q;

  always_ff @(posedge CLK_chaos or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      dato_q  <= '0;
      listo_q <= 1'b0;
      err_q   <= 1'b0;
      ocup_q  <= 1'b0;
    end else begin
      listo_q <= 1'b0;
      err_q   <= 1'b0;
      if (state_q == IDLE) begin
        to_q <= '0;
        if (bit_evt && !data_s) begin
          state_q <= DATA;
          ocup_q  <= 1'b1;
          cnt_q   <= '0;
        end
      end else if (bit_evt) begin
        to_q <= '0;
        case (state_q)
          DATA: begin
            // LSB arrives first, so shift in from the top.
            shreg_q <= {data_s, shreg_q[7:1]};
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= data_s;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            ocup_q  <= 1'b0;
            if (data_s && (^{shreg_q, par_q})) begin
              if (shreg_q == PS2_EXT) begin
                ext_q <= 1'b1;
              end else if (shreg_q == PS2_BREAK) begin
                brk_q <= 1'b1;
              end else if (brk_q) begin
                brk_q <= 1'b0;
                ext_q <= 1'b0;
`ifdef PS2_BREAK_CLEAR_EN
                if (shreg_q == dato_q) begin
                  dato_q  <= 8'h00;
                  listo_q <= 1'b1;
                end
`endif
              end else begin
                // Extended make codes are delivered as-is; the prefix is dropped.
                dato_q  <= shreg_q;
                listo_q <= 1'b1;
                if (ext_q) ext_q <= 1'b0;
              end
            end else begin
              err_q <= 1'b1;
              brk_q <= 1'b0;
              ext_q <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            ocup_q  <= 1'b0;
          end
        endcase
      end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
        // Sender stalled mid-frame: drop it and resync on the next start bit.
        state_q <= IDLE;
        ocup_q  <= 1'b0;
        to_q    <= '0;
        err_q   <= 1'b1;
        brk_q   <= 1'b0;
        ext_q   <= 1'b0;
      end else begin
        to_q <= to_q + TO_W'(1);
      end
    end
  end

  assign dato        = dato_q;
  assign dato_listo  = listo_q;
  assign error_trama = err_q;
  assign ocupado     = ocup_q;

endmodule

// File: tb/tb_ps2_receptor.sv
module tb_ps2_receptor;
  import ps2_pkg::*;

  localparam int HP  = 40;   // PS/2 half period in system cycles (scaled)
  localparam int TO  = 400;  // scaled timeout
  localparam int LAT = 11;   // 2 sync + FILTER_LEN filter + 1 register

  logic       CLK_chaos = 1'b0;
  logic       restart_n = 1'b0;
  logic       ps2_clk   = 1'b1;
  logic       ps2_data  = 1'b1;
  logic [7:0] dato;
  logic       dato_listo, error_trama, ocupado;

  int checks = 0, errors = 0;
  int cyc = 0, n_listo = 0, n_err = 0, stop_cyc = 0, listo_cyc = 0;
  int l0, e0;

  ps2_receptor #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
    .CLK_chaos   (CLK_chaos),
    .restart_n   (restart_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .dato        (dato),
    .dato_listo  (dato_listo),
    .error_trama (error_trama),
    .ocupado     (ocupado)
  );

  always #5 CLK_chaos = ~CLK_chaos;
  always @(posedge CLK_chaos) cyc++;

  always @(negedge CLK_chaos) begin
    if (restart_n) begin
      if (dato_listo) begin
        n_listo++;
        listo_cyc = cyc;
      end
      if (error_trama) n_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK_chaos);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic last);
    ps2_data = b;
    wait_cyc(HP);
    ps2_clk = 1'b0;
    if (last) stop_cyc = cyc;
    wait_cyc(HP);
    ps2_clk = 1'b1;
  endtask

  // Same bit, but with a 3-cycle glitch inside both clock phases.
  task automatic send_bit_glitch(input logic b);
    ps2_data = b;
    wait_cyc(15); ps2_clk = 1'b0;
    wait_cyc(3);  ps2_clk = 1'b1;
    wait_cyc(HP - 18);
    ps2_clk = 1'b0;
    wait_cyc(15); ps2_clk = 1'b1;
    wait_cyc(3);  ps2_clk = 1'b0;
    wait_cyc(HP - 18);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par_inv, input logic stopb);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i], 1'b0);
    send_bit((~^code) ^ par_inv, 1'b0);
    send_bit(stopb, 1'b1);
    ps2_data = 1'b1;
    wait_cyc(HP);
  endtask

  initial begin
    wait_cyc(3);
    chk("rst_dato",  dato, 8'h00);
    chk("rst_listo", dato_listo, 1'b0);
    chk("rst_err",   error_trama, 1'b0);
    chk("rst_ocup",  ocupado, 1'b0);
    restart_n = 1'b1;
    wait_cyc(HP);

    // good frame, latency and single pulse
    l0 = n_listo;
    send_frame(KEY_C, 1'b0, 1'b1);
    chk("c_dato",  dato, 8'h21);
    chk("c_pulse", n_listo - l0, 1);
    chk("c_lat",   listo_cyc - stop_cyc, LAT);
    chk("c_err",   n_err, 0);
    chk("c_ocup",  ocupado, 1'b0);

    // bad parity
    l0 = n_listo;
    send_frame(KEY_ENTER, 1'b1, 1'b1);
    chk("par_err",   n_err, 1);
    chk("par_dato",  dato, 8'h21);
    chk("par_listo", n_listo - l0, 0);

    // bad stop bit
    send_frame(KEY_S, 1'b0, 1'b0);
    chk("stop_err",  n_err, 2);
    chk("stop_dato", dato, 8'h21);

    // make, break, same key
    l0 = n_listo;
    send_frame(KEY_R, 1'b0, 1'b1);
    chk("r_dato", dato, 8'h2D);
    send_frame(PS2_BREAK, 1'b0, 1'b1);
    send_frame(KEY_R, 1'b0, 1'b1);
`ifdef PS2_BREAK_CLEAR_EN
    chk("brk_dato",  dato, 8'h00);
    chk("brk_listo", n_listo - l0, 2);
`else
    chk("brk_dato",  dato, 8'h2D);
    chk("brk_listo", n_listo - l0, 1);
`endif

    // extended prefix
    l0 = n_listo;
    send_frame(PS2_EXT, 1'b0, 1'b1);
    chk("ext_none", n_listo - l0, 0);
    send_frame(KEY_S, 1'b0, 1'b1);
    chk("ext_dato",  dato, 8'h1B);
    chk("ext_listo", n_listo - l0, 1);

    // typematic repeat
    send_frame(KEY_S, 1'b0, 1'b1);
    chk("rep_dato",  dato, 8'h1B);
    chk("rep_listo", n_listo - l0, 2);

    // timeout after 4 data bits
    e0 = n_err;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(KEY_G[i], 1'b0);
    chk("to_busy", ocupado, 1'b1);
    wait_cyc(TO + 100);
    chk("to_err",  n_err - e0, 1);
    chk("to_ocup", ocupado, 1'b0);
    send_frame(KEY_G, 1'b0, 1'b1);
    chk("to_dato",  dato, 8'h34);
    chk("to_clean", n_err - e0, 1);

    // glitched clock
    l0 = n_listo;
    e0 = n_err;
    send_bit_glitch(1'b0);
    for (int i = 0; i < 8; i++) send_bit_glitch(KEY_H[i]);
    send_bit_glitch(~^KEY_H);
    send_bit_glitch(1'b1);
    wait_cyc(HP);
    chk("gl_dato",  dato, 8'h33);
    chk("gl_listo", n_listo - l0, 1);
    chk("gl_err",   n_err - e0, 0);

    // reset mid-frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    restart_n = 1'b0;
    #1;
    chk("mr_dato",  dato, 8'h00);
    chk("mr_ocup",  ocupado, 1'b0);
    chk("mr_listo", dato_listo, 1'b0);
    wait_cyc(5);
    restart_n = 1'b1;
    wait_cyc(HP);
    send_frame(KEY_T, 1'b0, 1'b1);
    chk("mr_new", dato, 8'h2C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_receptor.md
Name: ps2_receptor

Overview:
- Upstream stage of the keyboard command decoder.
- Deserialises PS/2 keyboard frames (11 bits: start, 8 data LSB-first, odd parity, stop) from the raw ps2_clk/ps2_data pins.
- Filters out prefix and break codes.
- Presents the last valid make code as a held 8-bit level on dato, plus a one-cycle strobe; the decoder samples dato every CLK_chaos cycle.

Parameters:
- FILTER_LEN, 8: consecutive identical ps2_clk samples required before the filtered clock changes level.
- TIMEOUT_CYC, 20000: CLK_chaos cycles allowed between filtered falling edges inside a frame (200 us at 100 MHz).

Ports:
- CLK_chaos  input  1  system clock; all logic on its rising edge.
- restart_n  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
- ps2_data  input  1  raw PS/2 data pin, asynchronous.
- dato  output  8  last accepted make code, held until replaced or cleared.
- dato_listo  output  1  one-cycle pulse whenever dato is written.
- error_trama  output  1  one-cycle pulse on a parity, stop or timeout error.
- ocupado  output  1  high while a frame is in progress (state not IDLE).

Behaviour:
- Reset:
  - Asserting restart_n low immediately forces dato=8'h00, dato_listo=0, error_trama=0, ocupado=0, state=IDLE.
  - It also clears the bit counter, shift register, timeout counter and break/extended flags, and sets the filter history to all-ones.
  - A frame in progress when reset is asserted is discarded.
- Input conditioning:
  - Both pins pass through 2-FF synchronisers.
  - The filtered clock goes to 1 only after FILTER_LEN consecutive synchronised 1s, and to 0 only after FILTER_LEN consecutive 0s; otherwise it holds.
  - A bit event is a filtered 1->0 transition. The synchronised ps2_data is sampled in that same cycle.
- FSM states:
  - IDLE: on a bit event with data=0 go to DATA, bit counter=0. A bit event with data=1 is ignored.
  - DATA: shift the bit into the shift register from the MSB side, so the first bit received ends up as bit 0. After the 8th bit go to PARITY.
  - PARITY: store the bit, then go to STOP.
  - STOP: on the bit event, the frame is good when stop=1 and the XOR of the 8 data bits and the parity bit equals 1. Then go to IDLE.
- Timeout: in every state except IDLE the timeout counter increments each cycle and resets on each bit event. Reaching TIMEOUT_CYC is an error and forces IDLE.
- Error handling: any error (bad parity, stop=0, timeout) pulses error_trama for 1 cycle, discards the byte, clears break_pend and ext_pend, and leaves dato unchanged.
- Good-frame classification (code = received byte):
  - 8'hE0: set ext_pend. No output.
  - 8'hF0: set break_pend. No output.
  - break_pend=1: the code is a break. Clear break_pend and ext_pend. See Optional Feature.
  - Otherwise, a make code: dato<=code and dato_listo=1. ext_pend is cleared; extended codes are delivered unmodified.
- Latency: dato and dato_listo update exactly 1 cycle after the stop-bit event cycle.
- Typematic repeat: a repeated make code rewrites the same value and pulses dato_listo again.
- Back-to-back frames are accepted with no gap beyond the PS/2 protocol.
- ocupado is a registered decode of state != IDLE.

Optional Feature:
- Macro PS2_BREAK_CLEAR_EN.
- Defined: a break code equal to the current dato sets dato<=8'h00 and pulses dato_listo. This lets the downstream decoder see key release and leave its reset/command states. A break for any other code has no effect.
- Undefined: break codes are consumed silently and dato keeps the last make code.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0;
  - the key codes shared with the decoder: C=8'h21, G=8'h34, H=8'h33, T=8'h2C, ENTER=8'h5A, R=8'h2D, S=8'h1B.
- Sub-module ps2_filtro: synchroniser, glitch filter and falling-edge detector. Outputs are bit_evt and data_s.
- Frame FSM, timeout and code classification stay in ps2_receptor.

Test Plan:
- Frame 8'h21 (parity bit 1, stop 1) at a 12.5 kHz PS/2 clock -> dato=8'h21 and a single dato_listo pulse 1 cycle after the stop edge; error_trama stays 0.
- Frame 8'h5A with the parity bit inverted -> error_trama pulses once; dato keeps its previous value; no dato_listo.
- Sequence 8'h2D, 8'hF0, 8'h2D -> dato=8'h2D after the first frame. With PS2_BREAK_CLEAR_EN, dato=8'h00 after the third frame; without it, dato stays 8'h2D with exactly 1 dato_listo pulse total.
- Sequence 8'hE0, 8'h1B -> dato=8'h1B; no output after the E0 frame.
- Stop driving ps2_clk after 4 data bits for more than TIMEOUT_CYC cycles -> error_trama pulse, ocupado falls to 0, and the next full 8'h34 frame is received correctly.
- Inject 3-cycle ps2_clk glitches mid-bit -> no extra bit events; 8'h33 is received intact.
- Assert restart_n low mid-frame -> outputs zero at once; a new 8'h2C frame after release gives dato=8'h2C.
